// File: rtl/scaler_readout_seq_pkg.sv
// ============================================================================
// Module : scaler_readout_seq_pkg
// Brief  : Shared widths, reference-word tag and sequencer state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package scaler_readout_seq_pkg;

  localparam int SCAL_AW = 5;
  localparam int SCAL_DW = 16;

  localparam logic [SCAL_AW-1:0] REF_TAG = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HOLD   = 3'd5,
    ST_REF    = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/scaler_out_reg.sv
// ============================================================================
// Module : scaler_out_reg
// Brief  : One-entry valid/ready output register with a load port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scaler_out_reg
  import scaler_readout_seq_pkg::*;
(
  input  logic               clk33_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic [SCAL_DW-1:0] dat_i,
  input  logic [SCAL_AW-1:0] tag_i,
  input  logic               last_i,
  input  logic               ready_i,
  output logic [SCAL_DW-1:0] dat_o,
  output logic [SCAL_AW-1:0] tag_o,
  output logic               last_o,
  output logic               valid_o,
  output logic               free_o
);

  // The caller only loads when free_o is high, so a held word is never overwritten.
  assign free_o = !valid_o || ready_i;

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dat_o   <= '0;
      tag_o   <= '0;
      last_o  <= 1'b0;
      valid_o <= 1'b0;
    end else if (load_i) begin
      dat_o   <= dat_i;
      tag_o   <= tag_i;
      last_o  <= last_i;
      valid_o <= 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/scaler_readout_seq.sv
// ============================================================================
// Module : scaler_readout_seq
// Brief  : Latches the scalers, reads every address plus the reference count
//          and streams them out as a tagged valid/ready frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scaler_readout_seq
  import scaler_readout_seq_pkg::*;
#(
  parameter int NUM_SCALERS = 17,
  parameter int RD_LATENCY  = 2,
  parameter int SETTLE      = 1
) (
  input  logic               clk33_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  output logic               scal_rd_o,
  output logic [SCAL_AW-1:0] scal_addr_o,
  input  logic [SCAL_DW-1:0] scal_dat_i,
  input  logic [SCAL_DW-1:0] refpulse_cnt_i,
  output logic [SCAL_DW-1:0] dat_o,
  output logic [SCAL_AW-1:0] tag_o,
  output logic               last_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               busy_o,
  output logic [7:0]         overrun_o
);

  localparam logic [2:0]         c_wait_init   = 3'(RD_LATENCY - 1);
  localparam logic [2:0]         c_settle_init = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;
  localparam logic [SCAL_AW-1:0] c_last_addr   = SCAL_AW'(NUM_SCALERS - 1);

  state_t             r_state, w_state_nxt;
  logic [SCAL_AW-1:0] r_addr, w_addr_nxt;
  logic [SCAL_AW-1:0] r_scal_addr, w_scal_addr_nxt;
  logic [2:0]         r_wait, w_wait_nxt;
  logic [2:0]         r_settle, w_settle_nxt;
  logic [7:0]         r_overrun;

  logic               w_free;
  logic               w_capture;
  logic               w_load;
  logic [SCAL_DW-1:0] w_load_dat;
  logic [SCAL_AW-1:0] w_load_tag;
  logic               w_load_last;

  assign busy_o      = (r_state != ST_IDLE) || valid_o;
  assign scal_rd_o   = (r_state == ST_LATCH);
  assign scal_addr_o = r_scal_addr;
  assign overrun_o   = r_overrun;

  // The address stays put through HOLD, so scal_dat_i is still valid there.
  assign w_capture = w_free &&
                     (((r_state == ST_WAIT) && (r_wait == 3'd0)) || (r_state == ST_HOLD));

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_scal_addr_nxt = r_scal_addr;
    w_wait_nxt      = r_wait;
    w_settle_nxt    = r_settle;
    w_load          = 1'b0;
    w_load_dat      = scal_dat_i;
    w_load_tag      = r_addr;
    w_load_last     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start_i && !valid_o) w_state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        w_settle_nxt = c_settle_init;
        w_state_nxt  = (SETTLE == 0) ? ST_ISSUE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_settle == 3'd0) w_state_nxt = ST_ISSUE;
        else                  w_settle_nxt = r_settle - 3'd1;
      end
      ST_ISSUE: begin
        w_scal_addr_nxt = r_addr;
        w_wait_nxt      = c_wait_init;
        w_state_nxt     = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait != 3'd0) w_wait_nxt = r_wait - 3'd1;
        else if (!w_free)   w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
      end
      ST_REF: begin
        if (w_free) begin
          w_load      = 1'b1;
          w_load_dat  = refpulse_cnt_i;
          w_load_tag  = REF_TAG;
          w_load_last = 1'b1;
          w_addr_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_capture) begin
      w_load = 1'b1;
      if (r_addr == c_last_addr) begin
        w_state_nxt = ST_REF;
      end else begin
        w_addr_nxt  = r_addr + 1'b1;
        w_state_nxt = ST_ISSUE;
      end
    end
  end

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_scal_addr <= '0;
      r_wait      <= '0;
      r_settle    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_scal_addr <= w_scal_addr_nxt;
      r_wait      <= w_wait_nxt;
      r_settle    <= w_settle_nxt;
    end
  end

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i)                                      r_overrun <= '0;
    else if (start_i && busy_o && (r_overrun != 8'hFF)) r_overrun <= r_overrun + 8'd1;
  end

  scaler_out_reg u_out_reg (
    .clk33_i (clk33_i),
    .rst_n_i (rst_n_i),
    .load_i  (w_load),
    .dat_i   (w_load_dat),
    .tag_i   (w_load_tag),
    .last_i  (w_load_last),
    .ready_i (ready_i),
    .dat_o   (dat_o),
    .tag_o   (tag_o),
    .last_o  (last_o),
    .valid_o (valid_o),
    .free_o  (w_free)
  );

endmodule

`default_nettype wire

// File: tb/tb_scaler_readout_seq.sv
// ============================================================================
// Module : tb_scaler_readout_seq
// Brief  : Directed self-checking bench for scaler_readout_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scaler_readout_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, ready;
  logic        scal_rd, last, valid, busy;
  logic [4:0]  scal_addr, tag;
  logic [15:0] scal_dat, dat;
  logic [7:0]  overrun;
  logic [15:0] refcnt = 16'h00AA;

  logic        b_start, b_ready;
  logic        b_scal_rd, b_last, b_valid, b_busy;
  logic [4:0]  b_scal_addr, b_tag;
  logic [15:0] b_scal_dat, b_dat;
  logic [7:0]  b_overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #15 clk = ~clk;

  // Scaler model: one register stage gives RD_LATENCY=2 for the main instance.
  always @(posedge clk) scal_dat <= 16'h1000 + {11'd0, scal_addr};
  assign b_scal_dat = 16'h2000 + {11'd0, b_scal_addr};

  scaler_readout_seq #(.NUM_SCALERS(17), .RD_LATENCY(2), .SETTLE(1)) u_dut (
    .clk33_i(clk), .rst_n_i(rst_n), .start_i(start), .scal_rd_o(scal_rd),
    .scal_addr_o(scal_addr), .scal_dat_i(scal_dat), .refpulse_cnt_i(refcnt),
    .dat_o(dat), .tag_o(tag), .last_o(last), .valid_o(valid), .ready_i(ready),
    .busy_o(busy), .overrun_o(overrun)
  );

  scaler_readout_seq #(.NUM_SCALERS(1), .RD_LATENCY(1), .SETTLE(0)) u_bnd (
    .clk33_i(clk), .rst_n_i(rst_n), .start_i(b_start), .scal_rd_o(b_scal_rd),
    .scal_addr_o(b_scal_addr), .scal_dat_i(b_scal_dat), .refpulse_cnt_i(refcnt),
    .dat_o(b_dat), .tag_o(b_tag), .last_o(b_last), .valid_o(b_valid), .ready_i(b_ready),
    .busy_o(b_busy), .overrun_o(b_overrun)
  );

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drains a frame from word index 'first' with ready held high.
  task automatic collect_words(input string nm, input int first, input bit start_on_last,
                               input bit check_spacing);
    int idx = first;
    int cyc = 0;
    int last_cyc = 0;
    logic [15:0] e_dat;
    logic [4:0]  e_tag;
    logic        e_last;
    ready = 1'b1;
    while (idx < 18 && cyc < 400) begin
      if (valid && ready) begin
        e_dat  = (idx < 17) ? 16'h1000 + 16'(idx) : 16'h00AA;
        e_tag  = (idx < 17) ? 5'(idx) : 5'h1F;
        e_last = (idx == 17);
        n_cmp++;
        if (dat !== e_dat || tag !== e_tag || last !== e_last) begin
          n_err++;
          $display("FAIL %s word%0d: got dat=%h tag=%0d last=%b, expected dat=%h tag=%0d last=%b",
                   nm, idx, dat, tag, last, e_dat, e_tag, e_last);
        end
        if (check_spacing && idx >= 1 && idx <= 16) begin
          n_cmp++;
          if (cyc - last_cyc != 3) begin
            n_err++;
            $display("FAIL %s spacing%0d: got %0d cycles, expected 3", nm, idx, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        if (idx == 17 && start_on_last) start = 1'b1;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (idx != 18) begin
      n_err++;
      $display("FAIL %s count: got %0d words, expected 18", nm, idx);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_after: got %b, expected 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; b_start = 1'b0; b_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({scal_rd, scal_addr, dat, tag, last, valid, busy} !== 40'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rd=%b addr=%0d dat=%h tag=%0d last=%b valid=%b busy=%b, expected all 0",
               scal_rd, scal_addr, dat, tag, last, valid, busy);
    end
    n_cmp++;
    if (overrun !== 8'd0) begin
      n_err++;
      $display("FAIL reset_overrun: got %0d, expected 0", overrun);
    end
    n_cmp++;
    if ({b_valid, b_busy, b_scal_rd} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_bnd: got valid=%b busy=%b rd=%b, expected 0", b_valid, b_busy, b_scal_rd);
    end
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (scal_rd !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_rd: got %b, expected 0", scal_rd);
      end
    end
  endtask

  task automatic test_nominal_frame();
    int rd_cnt = 0;
    int lat = 0;
    int cyc = 0;
    ready = 1'b1;
    pulse_start();
    while (!valid && cyc < 50) begin
      if (scal_rd) rd_cnt++;
      if (rd_cnt > 0) lat++;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (rd_cnt != 1) begin
      n_err++;
      $display("FAIL nominal_rd_pulses: got %0d, expected 1", rd_cnt);
    end
    n_cmp++;
    if (lat != 5) begin
      n_err++;
      $display("FAIL nominal_first_latency: got %0d cycles, expected 5", lat);
    end
    collect_words("nominal", 0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    ready = 1'b0;
    pulse_start();
    while (!valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    repeat (10) begin
      @(negedge clk);
      n_cmp++;
      if (valid !== 1'b1 || dat !== 16'h1000 || tag !== 5'd0) begin
        n_err++;
        $display("FAIL bp_hold: got valid=%b dat=%h tag=%0d, expected 1 1000 0", valid, dat, tag);
      end
    end
    n_cmp++;
    if (scal_addr !== 5'd1) begin
      n_err++;
      $display("FAIL bp_addr: got %0d, expected 1", scal_addr);
    end
    collect_words("backpressure", 0, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    int extra = 0;
    ready = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk);
    repeat (3) begin
      pulse_start();
      @(negedge clk);
    end
    n_cmp++;
    if (overrun !== 8'd3) begin
      n_err++;
      $display("FAIL overrun_three: got %0d, expected 3", overrun);
    end
    collect_words("overrun", 0, 1'b0, 1'b0);
    repeat (20) begin
      @(negedge clk);
      if (valid || scal_rd) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL overrun_single_frame: got %0d extra active cycles, expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int rd_cnt = 0;
    ready = 1'b1;
    pulse_start();
    collect_words("back_to_back", 0, 1'b1, 1'b0);
    n_cmp++;
    if (overrun !== 8'd4) begin
      n_err++;
      $display("FAIL b2b_overrun: got %0d, expected 4", overrun);
    end
    repeat (10) begin
      @(negedge clk);
      if (scal_rd) rd_cnt++;
    end
    n_cmp++;
    if (rd_cnt != 0) begin
      n_err++;
      $display("FAIL b2b_no_restart: got %0d rd pulses, expected 0", rd_cnt);
    end
  endtask

  task automatic test_saturation();
    ready = 1'b0;
    pulse_start();
    start = 1'b1;
    repeat (300) @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (overrun !== 8'd255) begin
      n_err++;
      $display("FAIL overrun_saturate: got %0d, expected 255", overrun);
    end
    collect_words("saturation", 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int cyc = 0;
    ready = 1'b1;
    pulse_start();
    while (!(valid && tag == 5'd5) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || busy !== 1'b0 || overrun !== 8'd0) begin
      n_err++;
      $display("FAIL reset_mid: got valid=%b busy=%b overrun=%0d, expected 0 0 0", valid, busy, overrun);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    collect_words("after_reset", 0, 1'b0, 1'b1);
  endtask

  task automatic test_boundary();
    int cyc = 0;
    b_ready = 1'b1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    while (!b_scal_rd && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (b_scal_rd !== 1'b1) begin
      n_err++;
      $display("FAIL bnd_rd: got %b, expected 1", b_scal_rd);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (b_valid !== 1'b1 || b_dat !== 16'h2000 || b_tag !== 5'd0 || b_last !== 1'b0) begin
      n_err++;
      $display("FAIL bnd_word0: got valid=%b dat=%h tag=%0d last=%b, expected 1 2000 0 0",
               b_valid, b_dat, b_tag, b_last);
    end
    @(negedge clk);
    n_cmp++;
    if (b_valid !== 1'b1 || b_dat !== 16'h00AA || b_tag !== 5'h1F || b_last !== 1'b1) begin
      n_err++;
      $display("FAIL bnd_ref: got valid=%b dat=%h tag=%0d last=%b, expected 1 00aa 31 1",
               b_valid, b_dat, b_tag, b_last);
    end
    @(negedge clk);
    n_cmp++;
    if (b_valid !== 1'b0 || b_busy !== 1'b0) begin
      n_err++;
      $display("FAIL bnd_end: got valid=%b busy=%b, expected 0 0", b_valid, b_busy);
    end
  endtask

  initial begin
    test_reset();
    test_nominal_frame();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
